kvs_req_parser: RTL and testbench
=================================

// Module: kvs_req_parser
// PURPOSE
//  Parametrised memcache binary-protocol request front end for the KVS core.
//  It filters GMII receive frames for IPv4/UDP traffic to LISTEN_PORT and parses the 24-byte
//  memcache header, then captures the key into a local buffer while hashing it.
//  Each accepted request is presented as one descriptor on a valid/ready interface.
//  The hash/lookup engine downstream consumes the descriptor and reads the key from the buffer.
// PARAMETERS
//  LISTEN_PORT     16'd11211  UDP destination port accepted
//  PAYLOAD_OFFSET  50         byte index of memcache magic; 58 = with 8-byte UDP frame hdr
//  MAX_KEY_LEN     64         key buffer depth in bytes (>=1); longer keys are dropped
//  HASH_W          12         hash width (>=8)
// PORTS
//  gtx_clk         in   1        sole clock; rx_dv/rxd are synchronous to it
//  sys_rst         in   1        synchronous, active-high reset
//  rx_dv           in   1        GMII receive data valid
//  rxd             in   8        GMII receive byte
//  req_valid       out  1        descriptor valid
//  req_ready       in   1        descriptor accepted when valid&ready
//  req_opcode      out  8        00 GET, 01 SET, 04 DELETE
//  req_key_len     out  16       key length (1..MAX_KEY_LEN)
//  req_val_len     out  32       total_body - key_len - ext_len (mod 2^32)
//  req_opaque      out  32       opaque field, echoed in the response
//  req_hash        out  HASH_W   key hash
//  key_rd_addr     in   clog2(MAX_KEY_LEN)  key buffer read address
//  key_rd_data     out  8        combinational read; stable while req_valid
//  drop_cnt        out  16       dropped-frame count, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, rx_dv_d <= 1.
//    A frame already in progress at reset release is therefore ignored.
//  - Byte index b counts from 0 at the first rx_dv=1 byte (preamble byte 0).
//  - IDLE -> ETH on rx_dv & ~rx_dv_d.
//  - ETH: checks b20..21=0x0800, b22=0x45, b31=0x11, b44..45=LISTEN_PORT.
//    Any mismatch -> SKIP with a drop.
//  - Reaching b=PAYLOAD_OFFSET -> MCH (header byte h=0..23).
//  - MCH captures: h0 magic, h1 opcode, h2..3 key_len, h4 ext_len, h8..11 total_body, h12..15 opaque.
//    At h=23 the following are checks: magic=0x80, opcode in {00,01,04}, 1<=key_len<=MAX_KEY_LEN.
//    Fail -> SKIP with a drop. Pass -> EXT if ext_len!=0, otherwise KEY.
//  - EXT skips ext_len bytes, then goes to KEY.
//  - KEY writes byte k to buf[k] and updates the hash:
//    hash <= {hash[HASH_W-2:0],hash[HASH_W-1]} ^ {0,rxd}, with hash cleared at KEY entry.
//  - After the last key byte -> RESP; req_valid=1 on the next cycle (1-cycle latency).
//  - rx_dv falling in any state other than IDLE/SKIP/RESP -> IDLE with a drop; no descriptor.
//  - RESP: descriptor fields and the buffer are held until req_valid & req_ready.
//    On handshake: req_valid<=0; go to SKIP if rx_dv=1, otherwise IDLE.
//    A new frame start seen during RESP is dropped (+1), and RESP exits to SKIP.
//  - SKIP: wait for rx_dv=0, then IDLE.
//  - drop_cnt increments once per dropped frame; it never wraps.
//  - Value bytes are not captured here; a SET value is streamed by a separate block.
// TESTING
//  - GET, port 11211, key "foo" with req_ready=1:
//    req_valid pulses, opcode 00, key_len 3, val_len 0, hash 12'h129, key_rd_data[0..2]=66 6F 6F.
//  - SET, ext_len 8, key "k", total_body 14:
//    EXT bytes skipped; key_len 1, val_len 5, opaque echoed exactly.
//  - Frames that must each drop, leaving drop_cnt 3 and req_valid never high:
//    dst port 11212; key_len=MAX_KEY_LEN+1; rx_dv falling after 1 key byte.
//  - req_ready held 0 for 100 cycles while a second valid frame arrives:
//    first descriptor and key unchanged, drop_cnt +1; after ready only one handshake occurs.
//  - sys_rst asserted mid-KEY with rx_dv still high:
//    outputs 0, rest of that frame ignored; next frame parsed normally.
//  - Bad magic 0x81, then bad opcode 0x02: two drops; a valid GET follows immediately and is accepted.

Source files
------------

// File: rtl/kvs_req_parser.sv
// kvs_req_parser
//
// Memcache binary-protocol request front end. Watches a GMII receive stream,
// accepts only IPv4/UDP frames addressed to LISTEN_PORT, parses the 24-byte
// memcache request header and copies the key into a local buffer while
// hashing it. Each accepted request becomes one descriptor on a valid/ready
// interface. The downstream lookup engine reads the key through
// key_rd_addr/key_rd_data while the descriptor is pending.
//
// Ports
//   gtx_clk      sole clock, rx_dv/rxd synchronous to it
//   sys_rst      synchronous active-high reset
//   rx_dv, rxd   GMII receive data valid / byte
//   req_valid    descriptor valid, held until req_ready
//   req_ready    descriptor accepted when req_valid & req_ready
//   req_opcode   00 GET, 01 SET, 04 DELETE
//   req_key_len  key length, 1..MAX_KEY_LEN
//   req_val_len  total_body - key_len - ext_len (mod 2^32)
//   req_opaque   opaque field, echoed in the response
//   req_hash     rotate-xor hash of the key bytes
//   key_rd_addr  key buffer read address
//   key_rd_data  combinational key buffer read
//   drop_cnt     dropped-frame count, saturating
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a rising rx_dv (frame start, byte index 0)
// ETH   | preamble/Ethernet/IPv4/UDP bytes, checking type/proto/port
// MCH   | 24-byte memcache header, fields captured, checked at h=23
// EXT   | skipping ext_len extras bytes
// KEY   | writing key bytes to the buffer and hashing them
// RESP  | descriptor presented, fields and buffer frozen until handshake
// SKIP  | discarding the rest of the current frame

module kvs_req_parser #(
   parameter logic [15:0] LISTEN_PORT    = 16'd11211,
   parameter int unsigned PAYLOAD_OFFSET = 50,
   parameter int unsigned MAX_KEY_LEN    = 64,
   parameter int unsigned HASH_W         = 12,
   localparam int unsigned KAW = (MAX_KEY_LEN > 1) ? $clog2(MAX_KEY_LEN) : 1
) (
   input  logic              gtx_clk,
   input  logic              sys_rst,
   input  logic              rx_dv,
   input  logic [7:0]        rxd,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [7:0]        req_opcode,
   output logic [15:0]       req_key_len,
   output logic [31:0]       req_val_len,
   output logic [31:0]       req_opaque,
   output logic [HASH_W-1:0] req_hash,
   input  logic [KAW-1:0]    key_rd_addr,
   output logic [7:0]        key_rd_data,
   output logic [15:0]       drop_cnt
);

   localparam logic [15:0] PAYLOAD_LAST = 16'(PAYLOAD_OFFSET - 1);
   localparam logic [15:0] MAX_KEY16    = 16'(MAX_KEY_LEN);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ETH,
      ST_MCH,
      ST_EXT,
      ST_KEY,
      ST_RESP,
      ST_SKIP
   } state_t;

   state_t              state_q;
   logic                rx_dv_prev_q;
   logic [15:0]         b_q;
   logic [4:0]          h_q;
   logic [7:0]          e_q;
   logic [15:0]         k_q;
   logic [7:0]          magic_q;
   logic [7:0]          opcode_q;
   logic [15:0]         key_len_q;
   logic [7:0]          ext_len_q;
   logic [31:0]         total_q;
   logic [31:0]         opaque_q;
   logic [HASH_W-1:0]   hash_q;
   logic                pend_skip_q;
   logic [15:0]         drop_q;
   logic                req_valid_q;
   logic [7:0]          req_opcode_q;
   logic [15:0]         req_key_len_q;
   logic [31:0]         req_val_len_q;
   logic [31:0]         req_opaque_q;
   logic [HASH_W-1:0]   req_hash_q;
   logic [7:0]          key_buf [MAX_KEY_LEN];

   logic                frame_start;
   logic [15:0]         drop_inc;
   logic [HASH_W-1:0]   hash_nxt;
   logic                eth_bad;
   logic                op_ok;
   logic                hdr_ok;
   logic [31:0]         val_len;

   assign frame_start = rx_dv & ~rx_dv_prev_q;
   assign drop_inc    = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
   assign hash_nxt    = {hash_q[HASH_W-2:0], hash_q[HASH_W-1]} ^ HASH_W'(rxd);
   assign op_ok       = (opcode_q == 8'h00) || (opcode_q == 8'h01) || (opcode_q == 8'h04);
   assign hdr_ok      = (magic_q == 8'h80) && op_ok &&
                        (key_len_q != 16'd0) && (key_len_q <= MAX_KEY16);
   assign val_len     = total_q - {16'd0, key_len_q} - {24'd0, ext_len_q};

   // Header byte checks keyed on the byte index of the current rx byte.
   always_comb begin
      eth_bad = 1'b0;
      case (b_q)
         16'd20:  eth_bad = (rxd != 8'h08);
         16'd21:  eth_bad = (rxd != 8'h00);
         16'd22:  eth_bad = (rxd != 8'h45);
         16'd31:  eth_bad = (rxd != 8'h11);
         16'd44:  eth_bad = (rxd != LISTEN_PORT[15:8]);
         16'd45:  eth_bad = (rxd != LISTEN_PORT[7:0]);
         default: eth_bad = 1'b0;
      endcase
   end

   always_ff @(posedge gtx_clk) begin
      if (sys_rst) begin
         state_q       <= ST_IDLE;
         // Treat rx_dv as already high so a frame in flight at reset release is ignored.
         rx_dv_prev_q  <= 1'b1;
         b_q           <= '0;
         h_q           <= '0;
         e_q           <= '0;
         k_q           <= '0;
         magic_q       <= '0;
         opcode_q      <= '0;
         key_len_q     <= '0;
         ext_len_q     <= '0;
         total_q       <= '0;
         opaque_q      <= '0;
         hash_q        <= '0;
         pend_skip_q   <= 1'b0;
         drop_q        <= '0;
         req_valid_q   <= 1'b0;
         req_opcode_q  <= '0;
         req_key_len_q <= '0;
         req_val_len_q <= '0;
         req_opaque_q  <= '0;
         req_hash_q    <= '0;
         for (int i = 0; i < int'(MAX_KEY_LEN); i++) key_buf[i] <= 8'h00;
      end else begin
         rx_dv_prev_q <= rx_dv;
         case (state_q)
            ST_IDLE: begin
               if (frame_start) begin
                  state_q <= ST_ETH;
                  b_q     <= 16'd1;
               end
            end

            ST_ETH: begin
               if (!rx_dv) begin
                  state_q <= ST_IDLE;
                  drop_q  <= drop_inc;
               end else if (eth_bad) begin
                  state_q <= ST_SKIP;
                  drop_q  <= drop_inc;
               end else if (b_q == PAYLOAD_LAST) begin
                  state_q <= ST_MCH;
                  h_q     <= '0;
               end
               b_q <= b_q + 16'd1;
            end

            ST_MCH: begin
               if (!rx_dv) begin
                  state_q <= ST_IDLE;
                  drop_q  <= drop_inc;
               end else begin
                  case (h_q)
                     5'd0:  magic_q          <= rxd;
                     5'd1:  opcode_q         <= rxd;
                     5'd2:  key_len_q[15:8]  <= rxd;
                     5'd3:  key_len_q[7:0]   <= rxd;
                     5'd4:  ext_len_q        <= rxd;
                     5'd8, 5'd9, 5'd10, 5'd11:
                            total_q  <= {total_q[23:0], rxd};
                     5'd12, 5'd13, 5'd14, 5'd15:
                            opaque_q <= {opaque_q[23:0], rxd};
                     default: ;
                  endcase
                  if (h_q == 5'd23) begin
                     if (!hdr_ok) begin
                        state_q <= ST_SKIP;
                        drop_q  <= drop_inc;
                     end else if (ext_len_q != 8'd0) begin
                        state_q <= ST_EXT;
                        e_q     <= '0;
                     end else begin
                        state_q <= ST_KEY;
                        k_q     <= '0;
                        hash_q  <= '0;
                     end
                  end
                  h_q <= h_q + 5'd1;
               end
            end

            ST_EXT: begin
               if (!rx_dv) begin
                  state_q <= ST_IDLE;
                  drop_q  <= drop_inc;
               end else begin
                  if (e_q == ext_len_q - 8'd1) begin
                     state_q <= ST_KEY;
                     k_q     <= '0;
                     hash_q  <= '0;
                  end
                  e_q <= e_q + 8'd1;
               end
            end

            ST_KEY: begin
               if (!rx_dv) begin
                  state_q <= ST_IDLE;
                  drop_q  <= drop_inc;
               end else begin
                  key_buf[k_q[KAW-1:0]] <= rxd;
                  hash_q                <= hash_nxt;
                  if (k_q == key_len_q - 16'd1) begin
                     state_q       <= ST_RESP;
                     pend_skip_q   <= 1'b0;
                     req_valid_q   <= 1'b1;
                     req_opcode_q  <= opcode_q;
                     req_key_len_q <= key_len_q;
                     req_val_len_q <= val_len;
                     req_opaque_q  <= opaque_q;
                     req_hash_q    <= hash_nxt;
                  end
                  k_q <= k_q + 16'd1;
               end
            end

            ST_RESP: begin
               // A frame starting while the descriptor is pending cannot be parsed;
               // it is counted now and its tail is discarded after the handshake.
               if (frame_start) drop_q <= drop_inc;
               if (req_ready) begin
                  req_valid_q <= 1'b0;
                  pend_skip_q <= 1'b0;
                  state_q     <= (rx_dv || pend_skip_q) ? ST_SKIP : ST_IDLE;
               end else if (frame_start) begin
                  pend_skip_q <= 1'b1;
               end
            end

            ST_SKIP: begin
               if (!rx_dv) state_q <= ST_IDLE;
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_valid   = req_valid_q;
   assign req_opcode  = req_opcode_q;
   assign req_key_len = req_key_len_q;
   assign req_val_len = req_val_len_q;
   assign req_opaque  = req_opaque_q;
   assign req_hash    = req_hash_q;
   assign drop_cnt    = drop_q;
   assign key_rd_data = (32'(key_rd_addr) < MAX_KEY_LEN) ? key_buf[key_rd_addr] : 8'h00;

endmodule

// File: tb/tb_kvs_req_parser.sv
// tb_kvs_req_parser
//
// Directed frames are driven one byte per cycle; each frame that should
// produce a descriptor pushes a hand-computed expectation into a queue.
// A separate monitor pops and compares on every valid/ready handshake,
// including the key bytes read back through the key buffer port.

module tb_kvs_req_parser;

   localparam int KAW = 6;

   logic            gtx_clk = 1'b0;
   logic            sys_rst;
   logic            rx_dv;
   logic [7:0]      rxd;
   logic            req_valid;
   logic            req_ready;
   logic [7:0]      req_opcode;
   logic [15:0]     req_key_len;
   logic [31:0]     req_val_len;
   logic [31:0]     req_opaque;
   logic [11:0]     req_hash;
   logic [KAW-1:0]  key_rd_addr;
   logic [7:0]      key_rd_data;
   logic [15:0]     drop_cnt;

   kvs_req_parser #(
      .LISTEN_PORT    (16'd11211),
      .PAYLOAD_OFFSET (50),
      .MAX_KEY_LEN    (64),
      .HASH_W         (12)
   ) dut (
      .gtx_clk     (gtx_clk),
      .sys_rst     (sys_rst),
      .rx_dv       (rx_dv),
      .rxd         (rxd),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_opcode  (req_opcode),
      .req_key_len (req_key_len),
      .req_val_len (req_val_len),
      .req_opaque  (req_opaque),
      .req_hash    (req_hash),
      .key_rd_addr (key_rd_addr),
      .key_rd_data (key_rd_data),
      .drop_cnt    (drop_cnt)
   );

   always #10 gtx_clk = ~gtx_clk;

   typedef struct packed {
      logic [7:0]  opcode;
      logic [15:0] key_len;
      logic [31:0] val_len;
      logic [31:0] opaque;
      logic [11:0] hash;
      logic [63:0] key;     // byte i at key[8*i +: 8]
   } desc_t;

   desc_t      exp_q[$];
   logic [7:0] fr[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_hs    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_desc(input logic [7:0] opc, input logic [15:0] kl, input logic [31:0] vl,
                              input logic [31:0] opq, input logic [11:0] h, input logic [63:0] key);
      desc_t d;
      d.opcode  = opc;
      d.key_len = kl;
      d.val_len = vl;
      d.opaque  = opq;
      d.hash    = h;
      d.key     = key;
      exp_q.push_back(d);
   endtask

   task automatic build(input logic [15:0] port, input logic [7:0] magic, input logic [7:0] opc,
                        input logic [15:0] klen, input logic [7:0] ext, input logic [31:0] total,
                        input logic [31:0] opq, input logic [63:0] key, input int nkey, input int nval);
      fr.delete();
      repeat (7) fr.push_back(8'h55);
      fr.push_back(8'hD5);
      for (int i = 0; i < 6; i++) fr.push_back(8'h02);
      for (int i = 0; i < 6; i++) fr.push_back(8'h10 + 8'(i));
      fr.push_back(8'h08); fr.push_back(8'h00);
      fr.push_back(8'h45); fr.push_back(8'h00); fr.push_back(8'h00); fr.push_back(8'h40);
      fr.push_back(8'h00); fr.push_back(8'h00); fr.push_back(8'h40); fr.push_back(8'h00);
      fr.push_back(8'h40); fr.push_back(8'h11); fr.push_back(8'h00); fr.push_back(8'h00);
      repeat (4) fr.push_back(8'h0A);
      repeat (4) fr.push_back(8'h0B);
      fr.push_back(8'h30); fr.push_back(8'h39);
      fr.push_back(port[15:8]); fr.push_back(port[7:0]);
      fr.push_back(8'h00); fr.push_back(8'h30); fr.push_back(8'h00); fr.push_back(8'h00);
      fr.push_back(magic); fr.push_back(opc); fr.push_back(klen[15:8]); fr.push_back(klen[7:0]);
      fr.push_back(ext); fr.push_back(8'h00); fr.push_back(8'h00); fr.push_back(8'h00);
      for (int i = 3; i >= 0; i--) fr.push_back(total[8*i +: 8]);
      for (int i = 3; i >= 0; i--) fr.push_back(opq[8*i +: 8]);
      repeat (8) fr.push_back(8'h33);
      for (int i = 0; i < int'(ext); i++) fr.push_back(8'hEE);
      for (int i = 0; i < nkey; i++) fr.push_back(key[8*i +: 8]);
      for (int i = 0; i < nval; i++) fr.push_back(8'h56);
      repeat (4) fr.push_back(8'hCC);
   endtask

   task automatic drive(input logic dv, input logic [7:0] d);
      @(posedge gtx_clk);
      #1;
      rx_dv = dv;
      rxd   = d;
   endtask

   // cut < 0 sends the whole frame, otherwise only the first cut bytes.
   task automatic send(input int cut, input int gap);
      int n;
      n = (cut < 0) ? fr.size() : cut;
      for (int i = 0; i < n; i++) drive(1'b1, fr[i]);
      repeat (gap) drive(1'b0, 8'h00);
   endtask

   task automatic chk_drop(input logic [15:0] exp);
      @(negedge gtx_clk);
      chk("drop_cnt", 64'(drop_cnt), 64'(exp));
   endtask

   // Monitor: compare every handshake against the head of the queue.
   initial begin : monitor
      desc_t d;
      forever begin
         @(negedge gtx_clk);
         if (!sys_rst && req_valid && req_ready) begin
            n_hs++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_desc: got opcode %0h opaque %0h, expected no descriptor",
                        req_opcode, req_opaque);
            end else begin
               d = exp_q.pop_front();
               chk("opcode",  64'(req_opcode),  64'(d.opcode));
               chk("key_len", 64'(req_key_len), 64'(d.key_len));
               chk("val_len", 64'(req_val_len), 64'(d.val_len));
               chk("opaque",  64'(req_opaque),  64'(d.opaque));
               chk("hash",    64'(req_hash),    64'(d.hash));
               for (int i = 0; i < int'(d.key_len) && i < 8; i++) begin
                  key_rd_addr = KAW'(i);
                  #1;
                  chk($sformatf("key_byte%0d", i), 64'(key_rd_data), 64'(d.key[8*i +: 8]));
               end
            end
         end
      end
   end

   initial begin : stim
      int w;
      sys_rst     = 1'b1;
      rx_dv       = 1'b0;
      rxd         = 8'h00;
      req_ready   = 1'b1;
      key_rd_addr = '0;
      repeat (4) @(posedge gtx_clk);
      @(negedge gtx_clk);
      chk("rst_valid",   64'(req_valid),   64'd0);
      chk("rst_opcode",  64'(req_opcode),  64'd0);
      chk("rst_key_len", 64'(req_key_len), 64'd0);
      chk("rst_val_len", 64'(req_val_len), 64'd0);
      chk("rst_opaque",  64'(req_opaque),  64'd0);
      chk("rst_hash",    64'(req_hash),    64'd0);
      chk("rst_drop",    64'(drop_cnt),    64'd0);
      chk("rst_keydata", 64'(key_rd_data), 64'd0);
      @(posedge gtx_clk);
      #1;
      sys_rst = 1'b0;
      repeat (3) drive(1'b0, 8'h00);

      // GET "foo"
      expect_desc(8'h00, 16'd3, 32'd0, 32'hDEADBEEF, 12'h129, 64'h6F6F66);
      build(16'd11211, 8'h80, 8'h00, 16'd3, 8'd0, 32'd3, 32'hDEADBEEF, 64'h6F6F66, 3, 0);
      send(-1, 4);
      chk_drop(16'd0);

      // SET with 8 extras bytes, key "k", total_body 14
      expect_desc(8'h01, 16'd1, 32'd5, 32'hA5A55A5A, 12'h06B, 64'h6B);
      build(16'd11211, 8'h80, 8'h01, 16'd1, 8'd8, 32'd14, 32'hA5A55A5A, 64'h6B, 1, 5);
      send(-1, 4);
      chk_drop(16'd0);

      // Three dropped frames: wrong port, oversize key, rx_dv falls after 1 key byte
      build(16'd11212, 8'h80, 8'h00, 16'd3, 8'd0, 32'd3, 32'h11110001, 64'h6F6F66, 3, 0);
      send(-1, 4);
      chk_drop(16'd1);
      build(16'd11211, 8'h80, 8'h00, 16'd65, 8'd0, 32'd65, 32'h11110002, 64'h6F6F66, 3, 0);
      send(-1, 4);
      chk_drop(16'd2);
      build(16'd11211, 8'h80, 8'h00, 16'd3, 8'd0, 32'd3, 32'h11110003, 64'h6F6F66, 3, 0);
      send(75, 4);
      chk_drop(16'd3);

      // Back-pressure: descriptor held 100 cycles while a second frame arrives
      @(posedge gtx_clk);
      #1;
      req_ready = 1'b0;
      expect_desc(8'h00, 16'd2, 32'd0, 32'hCAFEF00D, 12'h0A0, 64'h6261);
      build(16'd11211, 8'h80, 8'h00, 16'd2, 8'd0, 32'd2, 32'hCAFEF00D, 64'h6261, 2, 0);
      send(-1, 2);
      w = 0;
      while (!req_valid && w < 50) begin
         @(negedge gtx_clk);
         w++;
      end
      chk("held_valid_seen", 64'(req_valid), 64'd1);
      build(16'd11211, 8'h80, 8'h00, 16'd3, 8'd0, 32'd3, 32'h22222222, 64'h6F6F66, 3, 0);
      send(-1, 2);
      repeat (17) drive(1'b0, 8'h00);
      chk_drop(16'd4);
      chk("held_valid",  64'(req_valid),  64'd1);
      chk("held_opaque", 64'(req_opaque), 64'hCAFEF00D);
      @(posedge gtx_clk);
      #1;
      req_ready = 1'b1;
      repeat (20) drive(1'b0, 8'h00);
      @(negedge gtx_clk);
      chk("held_valid_clr", 64'(req_valid), 64'd0);
      chk("held_hs_count",  64'(n_hs),      64'd3);

      // Bad magic, bad opcode, then a valid GET "xyz" right behind them
      build(16'd11211, 8'h81, 8'h00, 16'd3, 8'd0, 32'd3, 32'h33330001, 64'h6F6F66, 3, 0);
      send(-1, 1);
      build(16'd11211, 8'h80, 8'h02, 16'd3, 8'd0, 32'd3, 32'h33330002, 64'h6F6F66, 3, 0);
      send(-1, 1);
      expect_desc(8'h00, 16'd3, 32'd0, 32'h01020304, 12'h168, 64'h7A7978);
      build(16'd11211, 8'h80, 8'h00, 16'd3, 8'd0, 32'd3, 32'h01020304, 64'h7A7978, 3, 0);
      send(-1, 4);
      chk_drop(16'd6);

      // Reset asserted mid-key with rx_dv still high; rest of the frame ignored
      build(16'd11211, 8'h80, 8'h00, 16'd4, 8'd0, 32'd4, 32'h0BADF00D, 64'h64636261, 4, 0);
      for (int i = 0; i < fr.size(); i++) begin
         @(posedge gtx_clk);
         #1;
         rx_dv = 1'b1;
         rxd   = fr[i];
         if (i == 76) sys_rst = 1'b1;
         else if (i == 78) sys_rst = 1'b0;
      end
      repeat (4) drive(1'b0, 8'h00);
      key_rd_addr = 6'd2;
      @(negedge gtx_clk);
      chk("rst2_valid",   64'(req_valid),   64'd0);
      chk("rst2_drop",    64'(drop_cnt),    64'd0);
      chk("rst2_opaque",  64'(req_opaque),  64'd0);
      chk("rst2_hash",    64'(req_hash),    64'd0);
      chk("rst2_key_len", 64'(req_key_len), 64'd0);
      chk("rst2_keydata", 64'(key_rd_data), 64'd0);

      // Post-reset GET with an 8-byte key that wraps the hash rotation
      expect_desc(8'h00, 16'd8, 32'd0, 32'h76543210, 12'hF87, 64'h8080808080808080);
      build(16'd11211, 8'h80, 8'h00, 16'd8, 8'd0, 32'd8, 32'h76543210, 64'h8080808080808080, 8, 0);
      send(-1, 4);
      chk_drop(16'd0);

      w = 0;
      while (exp_q.size() != 0 && w < 100) begin
         @(negedge gtx_clk);
         w++;
      end
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      chk("hs_total",    64'(n_hs),         64'd5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
